// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg: shared state encoding, error codes and default header for the SPI frame parser
package spi_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        PAYLOAD,
        CHK,
        WRITE
    } state_t;

    localparam logic [1:0] ERR_ABORT = 2'd0;
    localparam logic [1:0] ERR_CHK   = 2'd1;
    localparam logic [1:0] ERR_LEN   = 2'd2;
    localparam logic [1:0] ERR_OVR   = 2'd3;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/spi_frame_parser_if.sv
// spi_frame_parser_if: byte stream in, register-write burst and frame status out
interface spi_frame_parser_if #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_ADDR_WIDTH = 8
) ();

    logic                    din_valid;
    logic [P_DATA_WIDTH-1:0] din;
    logic                    frame_abort;
    logic                    wr_en;
    logic [P_ADDR_WIDTH-1:0] wr_addr;
    logic [P_DATA_WIDTH-1:0] wr_data;
    logic                    frame_done;
    logic                    frame_err;
    logic [1:0]              err_code;

    modport master (
        output din_valid, din, frame_abort,
        input  wr_en, wr_addr, wr_data, frame_done, frame_err, err_code
    );

    modport slave (
        input  din_valid, din, frame_abort,
        output wr_en, wr_addr, wr_data, frame_done, frame_err, err_code
    );

endinterface

// File: rtl/spi_frame_buf.sv
// spi_frame_buf: payload store, one synchronous write port and one combinational read port
module spi_frame_buf #(
    parameter int P_MAX_LEN    = 16,
    parameter int P_DATA_WIDTH = 8,
    parameter int BW           = (P_MAX_LEN > 1) ? $clog2(P_MAX_LEN) : 1
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [BW-1:0]           waddr,
    input  logic [P_DATA_WIDTH-1:0] wdata,
    input  logic [BW-1:0]           raddr,
    output logic [P_DATA_WIDTH-1:0] rdata
);

    logic [P_DATA_WIDTH-1:0] mem [P_MAX_LEN];

    // contents need no reset: a frame is only written out after all its bytes were stored
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/spi_frame_parser.sv
// spi_frame_parser: extracts HEADER/ADDR/LEN/payload/CHK frames and issues a checksum-gated write burst
module spi_frame_parser
    import spi_frame_pkg::*;
#(
    parameter int                      P_DATA_WIDTH = 8,
    parameter int                      P_ADDR_WIDTH = 8,
    parameter int                      P_MAX_LEN    = 16,
    parameter logic [P_DATA_WIDTH-1:0] P_HEADER     = P_DATA_WIDTH'(DEFAULT_HEADER),
    parameter int                      P_TIMEOUT    = 1024
) (
    input logic               clk,
    input logic               rst_n,
    spi_frame_parser_if.slave bus
);

    localparam int LW = $clog2(P_MAX_LEN + 1);
    localparam int BW = (P_MAX_LEN > 1) ? $clog2(P_MAX_LEN) : 1;
    localparam int TW = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;
    localparam logic [TW-1:0]           T_LAST    = TW'(P_TIMEOUT - 1);
    localparam logic [P_DATA_WIDTH-1:0] MAX_LEN_B = P_DATA_WIDTH'(P_MAX_LEN);

    state_t                  state, state_n;
    logic [LW-1:0]           idx, idx_n, len, len_n;
    logic [P_ADDR_WIDTH-1:0] base, base_n, wr_addr_q, wr_addr_n;
    logic [P_DATA_WIDTH-1:0] chk, chk_n, wr_data_q, wr_data_n, rd_data;
    logic [TW-1:0]           tmo, tmo_n;
    logic                    ovr, ovr_n;
    logic                    wr_en_q, wr_en_n, done_q, done_n, err_q, err_n;
    logic [1:0]              code_q, code_n;
    logic                    buf_we, in_frame, last;

    spi_frame_buf #(
        .P_MAX_LEN   (P_MAX_LEN),
        .P_DATA_WIDTH(P_DATA_WIDTH),
        .BW          (BW)
    ) u_buf (
        .clk  (clk),
        .we   (buf_we),
        .waddr(BW'(idx)),
        .wdata(bus.din),
        .raddr(BW'(idx)),
        .rdata(rd_data)
    );

    // next-state and next-output logic; abort beats a same-cycle byte, a byte beats the timeout
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        len_n     = len;
        base_n    = base;
        chk_n     = chk;
        tmo_n     = '0;
        ovr_n     = ovr;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr_q;
        wr_data_n = wr_data_q;
        done_n    = 1'b0;
        err_n     = 1'b0;
        code_n    = code_q;
        buf_we    = 1'b0;
        in_frame  = state inside {ADDR, LEN, PAYLOAD, CHK};
        last      = (idx + LW'(1)) == len;
        if (in_frame && bus.frame_abort) begin
            err_n   = 1'b1;
            code_n  = ERR_ABORT;
            state_n = IDLE;
        end else if (in_frame && bus.din_valid) begin
            chk_n = chk ^ bus.din;
            case (state)
                ADDR: begin
                    base_n  = P_ADDR_WIDTH'(bus.din);
                    chk_n   = bus.din;
                    state_n = LEN;
                end
                LEN: begin
                    if (bus.din == '0 || bus.din > MAX_LEN_B) begin
                        err_n   = 1'b1;
                        code_n  = ERR_LEN;
                        state_n = IDLE;
                    end else begin
                        len_n   = LW'(bus.din);
                        idx_n   = '0;
                        state_n = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    buf_we  = 1'b1;
                    idx_n   = last ? '0 : idx + LW'(1);
                    state_n = last ? CHK : PAYLOAD;
                end
                default: begin
                    // idx is already 0 here, so rd_data is the first payload byte
                    if (bus.din == chk) begin
                        wr_en_n   = 1'b1;
                        wr_addr_n = base;
                        wr_data_n = rd_data;
                        idx_n     = LW'(1);
                        done_n    = len == LW'(1);
                        state_n   = done_n ? IDLE : WRITE;
                    end else begin
                        err_n   = 1'b1;
                        code_n  = ERR_CHK;
                        state_n = IDLE;
                    end
                end
            endcase
        end else if (in_frame && tmo == T_LAST) begin
            err_n   = 1'b1;
            code_n  = ERR_ABORT;
            state_n = IDLE;
        end else if (in_frame) begin
            tmo_n = tmo + TW'(1);
        end else if (state == WRITE) begin
            // bytes arriving during the burst are dropped but remembered as an overrun
            wr_en_n   = 1'b1;
            wr_addr_n = base + P_ADDR_WIDTH'(idx);
            wr_data_n = rd_data;
            idx_n     = idx + LW'(1);
            ovr_n     = ovr | bus.din_valid;
            if (last) begin
                done_n  = 1'b1;
                err_n   = ovr_n;
                code_n  = ovr_n ? ERR_OVR : code_q;
                state_n = IDLE;
            end
        end else begin
            ovr_n = 1'b0;
            if (bus.din_valid && bus.din == P_HEADER) state_n = ADDR;
        end
    end

    // state and registered outputs; asynchronous reset also cuts a burst in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            len       <= '0;
            base      <= '0;
            chk       <= '0;
            tmo       <= '0;
            ovr       <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            len       <= len_n;
            base      <= base_n;
            chk       <= chk_n;
            tmo       <= tmo_n;
            ovr       <= ovr_n;
            wr_en_q   <= wr_en_n;
            wr_addr_q <= wr_addr_n;
            wr_data_q <= wr_data_n;
            done_q    <= done_n;
            err_q     <= err_n;
            code_q    <= code_n;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.frame_done = done_q;
    assign bus.frame_err  = err_q;
    assign bus.err_code   = code_q;

endmodule

// File: tb/tb_spi_frame_parser.sv
// tb_spi_frame_parser: directed frame scenarios with hand-computed write bursts and status pulses
module tb_spi_frame_parser;
    import spi_frame_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    spi_frame_parser_if #(.P_DATA_WIDTH(8), .P_ADDR_WIDTH(8)) bus ();

    spi_frame_parser #(
        .P_DATA_WIDTH(8),
        .P_ADDR_WIDTH(8),
        .P_MAX_LEN   (16),
        .P_HEADER    (8'hA5),
        .P_TIMEOUT   (1024)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       done;
        logic       err;
        logic [1:0] code;
        logic       we;
        int         nwr;
    } ev_t;

    logic [15:0] wq[$];
    ev_t         evq[$];
    ev_t         mon_e;

    // log every write and every status pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.wr_en) wq.push_back({bus.wr_addr, bus.wr_data});
        if (bus.frame_done || bus.frame_err) begin
            mon_e.done = bus.frame_done;
            mon_e.err  = bus.frame_err;
            mon_e.code = bus.err_code;
            mon_e.we   = bus.wr_en;
            mon_e.nwr  = wq.size();
            evq.push_back(mon_e);
        end
    end

    function automatic logic [15:0] wr_at(input int i);
        return (i < wq.size()) ? wq[i] : 16'hxxxx;
    endfunction

    function automatic ev_t ev_at(input int i);
        ev_t d;
        d.done = 1'bx;
        d.err  = 1'bx;
        d.code = 2'bxx;
        d.we   = 1'bx;
        d.nwr  = -1;
        return (i < evq.size()) ? evq[i] : d;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.din = b;
        bus.din_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
    endtask

    task automatic send_good_20();
        send(8'hA5); send(8'h20); send(8'h01); send(8'h33); send(8'h12);
    endtask

    task automatic test_reset();
        bus.din_valid = 1'b0;
        bus.din = 8'h00;
        bus.frame_abort = 1'b0;
        rst_n = 1'b0;
        tick(3);
        vectors++; if (bus.wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en got %b want 0", bus.wr_en); end
        vectors++; if (bus.wr_addr !== 8'h00) begin miscompares++; $display("FAIL reset_wr_addr got %h want 00", bus.wr_addr); end
        vectors++; if (bus.wr_data !== 8'h00) begin miscompares++; $display("FAIL reset_wr_data got %h want 00", bus.wr_data); end
        vectors++; if (bus.frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bus.frame_done); end
        vectors++; if (bus.frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", bus.frame_err); end
        vectors++; if (bus.err_code !== 2'd0) begin miscompares++; $display("FAIL reset_code got %0d want 0", bus.err_code); end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_good_frame();
        int e0 = evq.size();
        send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h21);
        @(negedge clk);
        vectors++; if (bus.wr_en !== 1'b1) begin miscompares++; $display("FAIL good_w0_en got %b want 1", bus.wr_en); end
        vectors++; if ({bus.wr_addr, bus.wr_data} !== 16'h1011) begin miscompares++; $display("FAIL good_w0 got %h want 1011", {bus.wr_addr, bus.wr_data}); end
        vectors++; if (bus.frame_done !== 1'b0) begin miscompares++; $display("FAIL good_w0_done got %b want 0", bus.frame_done); end
        @(negedge clk);
        vectors++; if (bus.wr_en !== 1'b1) begin miscompares++; $display("FAIL good_w1_en got %b want 1", bus.wr_en); end
        vectors++; if ({bus.wr_addr, bus.wr_data} !== 16'h1122) begin miscompares++; $display("FAIL good_w1 got %h want 1122", {bus.wr_addr, bus.wr_data}); end
        vectors++; if ({bus.frame_done, bus.frame_err} !== 2'b10) begin miscompares++; $display("FAIL good_w1_status got %b want 10", {bus.frame_done, bus.frame_err}); end
        @(negedge clk);
        vectors++; if ({bus.wr_en, bus.frame_done} !== 2'b00) begin miscompares++; $display("FAIL good_after got %b want 00", {bus.wr_en, bus.frame_done}); end
        vectors++; if ({bus.wr_addr, bus.wr_data} !== 16'h1122) begin miscompares++; $display("FAIL good_hold got %h want 1122", {bus.wr_addr, bus.wr_data}); end
        tick(2);
        vectors++; if (evq.size() - e0 !== 1) begin miscompares++; $display("FAIL good_events got %0d want 1", evq.size() - e0); end
    endtask

    task automatic test_bad_checksum();
        int w0 = wq.size();
        int e0 = evq.size();
        ev_t e;
        send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h20);
        tick(4);
        e = ev_at(e0);
        vectors++; if ({e.done, e.err, e.code} !== {1'b0, 1'b1, ERR_CHK}) begin miscompares++; $display("FAIL chk_err got %b%b%0d want 011", e.done, e.err, e.code); end
        vectors++; if (wq.size() !== w0) begin miscompares++; $display("FAIL chk_no_write got %0d want %0d", wq.size(), w0); end
        send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h21);
        tick(4);
        vectors++; if (wr_at(w0) !== 16'h1011) begin miscompares++; $display("FAIL chk_next_w0 got %h want 1011", wr_at(w0)); end
        vectors++; if (wr_at(w0 + 1) !== 16'h1122) begin miscompares++; $display("FAIL chk_next_w1 got %h want 1122", wr_at(w0 + 1)); end
        e = ev_at(e0 + 1);
        vectors++; if ({e.done, e.err, e.we} !== 3'b101) begin miscompares++; $display("FAIL chk_next_done got %b want 101", {e.done, e.err, e.we}); end
    endtask

    task automatic test_bad_length();
        int w0 = wq.size();
        int e0 = evq.size();
        ev_t e;
        send(8'hA5); send(8'h10); send(8'h00);
        send(8'hA5); send(8'h10); send(8'h11);
        tick(3);
        vectors++; if (evq.size() - e0 !== 2) begin miscompares++; $display("FAIL len_events got %0d want 2", evq.size() - e0); end
        e = ev_at(e0);
        vectors++; if ({e.done, e.err, e.code} !== {1'b0, 1'b1, ERR_LEN}) begin miscompares++; $display("FAIL len_zero got %b%b%0d want 012", e.done, e.err, e.code); end
        e = ev_at(e0 + 1);
        vectors++; if ({e.done, e.err, e.code} !== {1'b0, 1'b1, ERR_LEN}) begin miscompares++; $display("FAIL len_17 got %b%b%0d want 012", e.done, e.err, e.code); end
        vectors++; if (wq.size() !== w0) begin miscompares++; $display("FAIL len_no_write got %0d want %0d", wq.size(), w0); end
    endtask

    task automatic test_addr_wrap();
        int w0 = wq.size();
        int e0 = evq.size();
        ev_t e;
        send(8'h00); send(8'hFF); send(8'h5A);
        send(8'hA5); send(8'hFF); send(8'h02); send(8'h01); send(8'h02); send(8'hFE);
        tick(4);
        vectors++; if (wr_at(w0) !== 16'hFF01) begin miscompares++; $display("FAIL wrap_w0 got %h want FF01", wr_at(w0)); end
        vectors++; if (wr_at(w0 + 1) !== 16'h0002) begin miscompares++; $display("FAIL wrap_w1 got %h want 0002", wr_at(w0 + 1)); end
        vectors++; if (evq.size() - e0 !== 1) begin miscompares++; $display("FAIL wrap_events got %0d want 1", evq.size() - e0); end
        e = ev_at(e0);
        vectors++; if ({e.done, e.err} !== 2'b10) begin miscompares++; $display("FAIL wrap_done got %b want 10", {e.done, e.err}); end
    endtask

    task automatic test_abort();
        int w0 = wq.size();
        int e0 = evq.size();
        ev_t e;
        send(8'hA5); send(8'h10); send(8'h03); send(8'h11);
        bus.frame_abort = 1'b1;
        bus.din = 8'h22;
        bus.din_valid = 1'b1;
        tick(1);
        bus.frame_abort = 1'b0;
        bus.din_valid = 1'b0;
        tick(3);
        e = ev_at(e0);
        vectors++; if ({e.done, e.err, e.code} !== {1'b0, 1'b1, ERR_ABORT}) begin miscompares++; $display("FAIL abort_err got %b%b%0d want 010", e.done, e.err, e.code); end
        vectors++; if (evq.size() - e0 !== 1) begin miscompares++; $display("FAIL abort_events got %0d want 1", evq.size() - e0); end
        send_good_20();
        tick(3);
        vectors++; if (wr_at(w0) !== 16'h2033) begin miscompares++; $display("FAIL abort_next_w got %h want 2033", wr_at(w0)); end
        e = ev_at(e0 + 1);
        vectors++; if ({e.done, e.err, e.we} !== 3'b101) begin miscompares++; $display("FAIL abort_next_done got %b want 101", {e.done, e.err, e.we}); end
    endtask

    task automatic test_timeout();
        int w0 = wq.size();
        int e0 = evq.size();
        int n = 0;
        ev_t e;
        send(8'hA5); send(8'h10); send(8'h03); send(8'h11);
        while (evq.size() == e0 && n < 2000) begin
            tick(1);
            n++;
        end
        vectors++; if (n < 1020 || n > 1028) begin miscompares++; $display("FAIL timeout_cycles got %0d want 1020..1028", n); end
        e = ev_at(e0);
        vectors++; if ({e.done, e.err, e.code} !== {1'b0, 1'b1, ERR_ABORT}) begin miscompares++; $display("FAIL timeout_err got %b%b%0d want 010", e.done, e.err, e.code); end
        send_good_20();
        tick(3);
        vectors++; if (wr_at(w0) !== 16'h2033) begin miscompares++; $display("FAIL timeout_next_w got %h want 2033", wr_at(w0)); end
    endtask

    task automatic test_overrun();
        int w0 = wq.size();
        int e0 = evq.size();
        ev_t e;
        send(8'hA5); send(8'h00); send(8'h04);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h00);
        send(8'h55);
        tick(6);
        vectors++; if (wq.size() - w0 !== 4) begin miscompares++; $display("FAIL ovr_count got %0d want 4", wq.size() - w0); end
        vectors++; if (wr_at(w0) !== 16'h0001) begin miscompares++; $display("FAIL ovr_w0 got %h want 0001", wr_at(w0)); end
        vectors++; if (wr_at(w0 + 3) !== 16'h0304) begin miscompares++; $display("FAIL ovr_w3 got %h want 0304", wr_at(w0 + 3)); end
        e = ev_at(e0);
        vectors++; if ({e.done, e.err, e.code, e.we} !== {1'b1, 1'b1, ERR_OVR, 1'b1}) begin miscompares++; $display("FAIL ovr_status got %b%b%0d%b want 1131", e.done, e.err, e.code, e.we); end
        vectors++; if (e.nwr !== w0 + 4) begin miscompares++; $display("FAIL ovr_last got %0d want %0d", e.nwr, w0 + 4); end
        send_good_20();
        tick(3);
        e = ev_at(e0 + 1);
        vectors++; if ({e.done, e.err} !== 2'b10) begin miscompares++; $display("FAIL ovr_cleared got %b want 10", {e.done, e.err}); end
    endtask

    task automatic test_reset_mid_write();
        int w0 = wq.size();
        send(8'hA5); send(8'h00); send(8'h04);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h00);
        @(negedge clk);
        vectors++; if (bus.wr_en !== 1'b1) begin miscompares++; $display("FAIL rstw_first got %b want 1", bus.wr_en); end
        #1 rst_n = 1'b0;
        #1;
        vectors++; if ({bus.wr_en, bus.frame_done} !== 2'b00) begin miscompares++; $display("FAIL rstw_cut got %b want 00", {bus.wr_en, bus.frame_done}); end
        @(negedge clk);
        rst_n = 1'b1;
        tick(6);
        vectors++; if (wq.size() - w0 !== 1) begin miscompares++; $display("FAIL rstw_count got %0d want 1", wq.size() - w0); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_length();
        test_addr_wrap();
        test_abort();
        test_timeout();
        test_overrun();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
